// File: rtl/instr_loader_pkg.sv
// Shared types and sizing for the boot-time instruction memory loader.
// The header length and word packing geometry are defined once here.
package instr_loader_pkg;

    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned HDR_BYTES      = 2;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned CNT_W          = HDR_BYTES * BYTE_W;
    localparam int unsigned WORD_W         = BYTES_PER_WORD * BYTE_W;
    localparam int unsigned BCNT_W         = $clog2(BYTES_PER_WORD);

    typedef enum logic [2:0] {
        LEN_HI = 3'd0,
        LEN_LO = 3'd1,
        DATA   = 3'd2,
        FLUSH  = 3'd3,
        DONE   = 3'd4,
        ERR    = 3'd5
    } state_e;

    // Header word count is transmitted high byte first.
    function automatic logic [CNT_W-1:0] hdr_count(input logic [BYTE_W-1:0] hi,
                                                   input logic [BYTE_W-1:0] lo);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/byte_word_packer.sv
// Assembles big-endian bytes into words; flags the word combinationally on
// acceptance of its last byte so the caller can register it one cycle later.
module byte_word_packer
    import instr_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              byte_en,
    input  logic [BYTE_W-1:0] byte_data,
    output logic              word_valid_c,
    output logic [WORD_W-1:0] word_data_c
);

    localparam int unsigned SHR_W = WORD_W - BYTE_W;

    logic [BCNT_W-1:0] byte_cnt_q;
    logic [SHR_W-1:0]  shr_q;

    // Byte position within the current word plus the bytes seen so far.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            byte_cnt_q <= '0;
            shr_q      <= '0;
        end else if (byte_en) begin
            byte_cnt_q <= BCNT_W'(byte_cnt_q + 1'b1);
            shr_q      <= {shr_q[SHR_W-BYTE_W-1:0], byte_data};
        end
    end

    assign word_valid_c = byte_en && (byte_cnt_q == BCNT_W'(BYTES_PER_WORD - 1));
    assign word_data_c  = {shr_q, byte_data};

endmodule

// File: rtl/instr_mem_loader.sv
// Boot loader: parses a length-prefixed byte stream, writes the words into the
// instruction memory and holds the CPU in reset until the image is complete.
module instr_mem_loader
    import instr_loader_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 32,
    parameter int unsigned ADDR_W      = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              byte_valid_i,
    input  logic [BYTE_W-1:0] byte_data_i,
    output logic              byte_ready_o,
    output logic              im_we_o,
    output logic [ADDR_W-1:0] im_addr_o,
    output logic [WORD_W-1:0] im_data_o,
    output logic              cpu_rst_o,
    output logic              done_o,
    output logic              err_o,
    output logic [CNT_W-1:0]  words_o
);

    state_e             state_q;
    state_e             state_nxt;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_nxt;
    logic [CNT_W-1:0]   word_idx_q;
    logic [CNT_W-1:0]   hdr_count_c;
    logic               accept_c;
    logic               data_byte_c;
    logic               word_valid_c;
    logic               last_word_c;
    logic [WORD_W-1:0]  word_data_c;

    assign byte_ready_o = (state_q == LEN_HI) || (state_q == LEN_LO) || (state_q == DATA);
    assign accept_c     = byte_valid_i && byte_ready_o;
    assign data_byte_c  = accept_c && (state_q == DATA);
    assign hdr_count_c  = hdr_count(count_q[CNT_W-1 -: BYTE_W], byte_data_i);
    assign last_word_c  = word_valid_c && (CNT_W'(word_idx_q + 1'b1) == count_q);

    byte_word_packer u_packer (
        .clk          (clk_i),
        .rst_n        (rst_i),
        .byte_en      (data_byte_c),
        .byte_data    (byte_data_i),
        .word_valid_c (word_valid_c),
        .word_data_c  (word_data_c)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= LEN_HI;
            count_q <= '0;
        end else begin
            state_q <= state_nxt;
            count_q <= count_nxt;
        end
    end

    // Header parsing and image sequencing; DONE and ERR only leave via reset.
    always_comb begin
        state_nxt = state_q;
        count_nxt = count_q;
        unique case (state_q)
            LEN_HI: begin
                if (accept_c) begin
                    count_nxt = {byte_data_i, {BYTE_W{1'b0}}};
                    state_nxt = LEN_LO;
                end
            end
            LEN_LO: begin
                if (accept_c) begin
                    count_nxt = hdr_count_c;
                    if (hdr_count_c == '0) begin
                        state_nxt = DONE;
                    end else if (32'(hdr_count_c) > DEPTH_WORDS) begin
                        state_nxt = ERR;
                    end else begin
                        state_nxt = DATA;
                    end
                end
            end
            DATA: begin
                if (last_word_c) begin
                    state_nxt = FLUSH;
                end
            end
            FLUSH:   state_nxt = DONE;
            DONE:    state_nxt = DONE;
            ERR:     state_nxt = ERR;
            default: state_nxt = LEN_HI;
        endcase
    end

    // Write port and status registers; status follows the next state so the
    // CPU is released only once the FLUSH write has been issued.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            im_we_o    <= 1'b0;
            im_addr_o  <= '0;
            im_data_o  <= '0;
            word_idx_q <= '0;
            words_o    <= '0;
            done_o     <= 1'b0;
            cpu_rst_o  <= 1'b0;
            err_o      <= 1'b0;
        end else begin
            im_we_o <= word_valid_c;
            if (word_valid_c) begin
                im_addr_o  <= ADDR_W'({word_idx_q, {BCNT_W{1'b0}}});
                im_data_o  <= word_data_c;
                word_idx_q <= CNT_W'(word_idx_q + 1'b1);
            end
            if (im_we_o) begin
                words_o <= CNT_W'(words_o + 1'b1);
            end
            done_o    <= (state_nxt == DONE);
            cpu_rst_o <= (state_nxt == DONE);
            err_o     <= (state_nxt == ERR);
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: directed images plus randomized
// images with random valid gaps, checked against an expected-write queue.
module tb_instr_mem_loader;

    localparam int unsigned DEPTH = 32;
    localparam int unsigned AW    = 32;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        byte_valid_i;
    logic [7:0]  byte_data_i;
    logic        byte_ready_o;
    logic        im_we_o;
    logic [AW-1:0] im_addr_o;
    logic [31:0] im_data_o;
    logic        cpu_rst_o;
    logic        done_o;
    logic        err_o;
    logic [15:0] words_o;

    always #5 clk = ~clk;

    instr_mem_loader #(.DEPTH_WORDS(DEPTH), .ADDR_W(AW)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .byte_valid_i (byte_valid_i),
        .byte_data_i  (byte_data_i),
        .byte_ready_o (byte_ready_o),
        .im_we_o      (im_we_o),
        .im_addr_o    (im_addr_o),
        .im_data_o    (im_data_o),
        .cpu_rst_o    (cpu_rst_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .words_o      (words_o)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_cmp   = 0;
    int  n_fail  = 0;
    int  gap_pct = 0;
    int  img_idx = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Every write pulse must match the oldest outstanding expected write.
    always begin
        @(posedge clk);
        #1;
        if (rst_i === 1'b1 && im_we_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write_addr", im_addr_o, 32'hFFFF_FFFF);
            end else begin
                check("write_addr", im_addr_o, exp_q[0].addr);
                check("write_data", im_data_o, exp_q[0].data);
                check("cpu_rst_during_write", 32'(cpu_rst_o), 32'd0);
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic do_reset();
        rst_i        = 1'b0;
        byte_valid_i = 1'b0;
        byte_data_i  = 8'h00;
        tick();
        tick();
        rst_i = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int guard;
        if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
            byte_valid_i = 1'b0;
            byte_data_i  = 8'($urandom);
            repeat ($urandom_range(3, 1)) tick();
        end
        byte_valid_i = 1'b1;
        byte_data_i  = b;
        guard = 0;
        while (byte_ready_o !== 1'b1 && guard < 50) begin
            tick();
            guard++;
        end
        check("byte_ready_when_offered", 32'(byte_ready_o), 32'd1);
        tick();
        byte_valid_i = 1'b0;
    endtask

    task automatic send_header(input logic [15:0] n);
        img_idx = 0;
        send_byte(n[15:8]);
        send_byte(n[7:0]);
    endtask

    task automatic send_word(input logic [31:0] w, input int gap_after);
        wr_t e;
        e.addr = 32'(img_idx) * 32'd4;
        e.data = w;
        exp_q.push_back(e);
        img_idx++;
        for (int i = 0; i < 4; i++) begin
            send_byte(w[31 - 8*i -: 8]);
            if (i == gap_after) repeat (3) tick();
        end
    endtask

    // Called right after the last data byte has been accepted.
    task automatic finish_check(input int n);
        check("flush_we", 32'(im_we_o), 32'd1);
        check("flush_done", 32'(done_o), 32'd0);
        check("flush_cpu_rst", 32'(cpu_rst_o), 32'd0);
        tick();
        check("done", 32'(done_o), 32'd1);
        check("cpu_rst_release", 32'(cpu_rst_o), 32'd1);
        check("ready_after_done", 32'(byte_ready_o), 32'd0);
        check("words", 32'(words_o), 32'(n));
        tick();
        check("pending_writes", 32'(exp_q.size()), 32'd0);
        check("done_held", 32'(done_o), 32'd1);
    endtask

    task automatic check_reset_state();
        check("rst_ready", 32'(byte_ready_o), 32'd1);
        check("rst_we", 32'(im_we_o), 32'd0);
        check("rst_addr", im_addr_o, 32'd0);
        check("rst_data", im_data_o, 32'd0);
        check("rst_cpu_rst", 32'(cpu_rst_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_words", 32'(words_o), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_i        = 1'b0;
        byte_valid_i = 1'b0;
        byte_data_i  = 8'h00;

        // Reset state and the back-to-back two-word image.
        do_reset();
        check_reset_state();
        send_header(16'h0002);
        send_word(32'h2008_0005, -1);
        send_word(32'h0000_4020, -1);
        finish_check(2);

        // Empty image: done one cycle after the second header byte, no write.
        do_reset();
        send_header(16'h0000);
        check("n0_done", 32'(done_o), 32'd1);
        check("n0_cpu_rst", 32'(cpu_rst_o), 32'd1);
        check("n0_ready", 32'(byte_ready_o), 32'd0);
        repeat (5) tick();
        check("n0_words", 32'(words_o), 32'd0);

        // Oversized header: error, CPU kept in reset despite further bytes.
        do_reset();
        send_header(16'(DEPTH + 1));
        check("err_flag", 32'(err_o), 32'd1);
        check("err_ready", 32'(byte_ready_o), 32'd0);
        check("err_cpu_rst", 32'(cpu_rst_o), 32'd0);
        byte_valid_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            byte_data_i = 8'($urandom);
            tick();
        end
        byte_valid_i = 1'b0;
        check("err_held", 32'(err_o), 32'd1);
        check("err_ready_held", 32'(byte_ready_o), 32'd0);
        check("err_cpu_rst_held", 32'(cpu_rst_o), 32'd0);
        check("err_words", 32'(words_o), 32'd0);
        check("err_done", 32'(done_o), 32'd0);

        // Same two-word image with random gaps and a forced 3-cycle mid-word gap.
        do_reset();
        gap_pct = 50;
        send_header(16'h0002);
        send_word(32'h2008_0005, -1);
        send_word(32'h0000_4020, 1);
        finish_check(2);
        gap_pct = 0;

        // Reset after 5 data bytes of a 3-word image, then a fresh 1-word image.
        do_reset();
        send_header(16'h0003);
        send_word(32'hDEAD_BEEF, -1);
        send_byte(8'h12);
        do_reset();
        check_reset_state();
        send_header(16'h0001);
        send_word(32'h0000_0001, -1);
        finish_check(1);

        // Full-depth image and random-length images with random gaps.
        for (int t = 0; t < 4; t++) begin
            n = (t == 0) ? int'(DEPTH) : int'($urandom_range(DEPTH, 1));
            gap_pct = int'($urandom_range(60));
            do_reset();
            send_header(16'(n));
            for (int k = 0; k < n; k++) begin
                send_word($urandom, -1);
            end
            finish_check(n);
        end
        gap_pct = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_mem_loader.md
# instr_mem_loader

- Boot-time writer for the instruction memory that the single-cycle CPU fetches from.
- Takes a byte stream (length header plus big-endian instruction words) over a valid/ready handshake.
- Packs the bytes into 32-bit words and writes them through the instruction memory's write port at consecutive word addresses.
- Holds the CPU in reset until the image is fully written, then releases it.

## Interface
Parameters:
- DEPTH_WORDS, 32, instruction memory capacity in words.
- ADDR_W, 32, width of the byte address driven to the memory.

Ports:
- clk_i  in  1  clock; all logic is on the rising edge.
- rst_i  in  1  reset; synchronous, active-low.
- byte_valid_i  in  1  an input byte is present.
- byte_data_i  in  8  input byte.
- byte_ready_o  out  1  loader can accept a byte this cycle.
- im_we_o  out  1  instruction memory write strobe; one-cycle pulse per word.
- im_addr_o  out  ADDR_W  byte address; always word-aligned.
- im_data_o  out  32  instruction word to be written.
- cpu_rst_o  out  1  CPU reset; active-low, low holds the CPU in reset.
- done_o  out  1  image fully loaded.
- err_o  out  1  header word count exceeds DEPTH_WORDS.
- words_o  out  16  number of words written so far.

## Operation
- A byte is accepted in any cycle where byte_valid_i && byte_ready_o are both high; nothing else counts as a transfer.
- Stream format:
  - 2 header bytes: word count N, 16-bit, high byte first.
  - Then N×4 data bytes, each word big-endian (first byte goes to bits [31:24]).
- States, with their transitions:
  - LEN_HI: accept byte into count[15:8], then go to LEN_LO.
  - LEN_LO: accept byte into count[7:0]. Then:
    - N=0 → DONE;
    - N>DEPTH_WORDS → ERR;
    - otherwise → DATA.
  - DATA: accept bytes into the packer.
    - On the 4th byte of a word, latch the word and its address, and raise im_we_o next cycle.
    - After the N-th word is accepted → FLUSH.
  - FLUSH: one cycle; the final write pulse is issued here; go to DONE.
  - DONE: terminal. done_o=1 and cpu_rst_o=1.
  - ERR: terminal. err_o=1 and cpu_rst_o stays 0.
- byte_ready_o = 1 in LEN_HI, LEN_LO and DATA; 0 in FLUSH, DONE and ERR.
- Addressing:
  - Word k (0-based) is written to im_addr_o = k<<2, zero-extended to ADDR_W.
  - The word index counter never wraps, because N ≤ DEPTH_WORDS is checked at the header.
- words_o increments in the cycle im_we_o is high.
- The word assembly register is separate from the im_data_o register, so the next word's first byte can be accepted in the same cycle as the previous word's write pulse.
- Reset mid-stream:
  - All state returns to LEN_HI and the CPU goes back into reset.
  - Memory contents that were already written are not cleared.
  - The next byte is treated as a new header.

## Timing
- Reset values:
  - byte_ready_o=1 (the state after reset is LEN_HI);
  - im_we_o=0, im_addr_o=0, im_data_o=0;
  - cpu_rst_o=0, done_o=0, err_o=0, words_o=0.
- All outputs are registered except byte_ready_o, which is decoded from the state register.
- Write latency: 4th byte of a word accepted in cycle t → im_we_o=1 in cycle t+1, with matching addr/data, for exactly one cycle.
- Completion: last byte accepted in cycle t → final write pulse at t+1 (FLUSH) → done_o=1 and cpu_rst_o=1 from t+2 onward. The CPU never exits reset in the same cycle as a memory write.
- Header with N=0: LEN_LO accepted at t → done_o and cpu_rst_o high from t+1; no write occurs.
- Header with N>DEPTH_WORDS: LEN_LO accepted at t → err_o=1 from t+1 and byte_ready_o=0. Only rst_i exits ERR.
- Throughput: one byte per cycle sustained, so one word every 4 cycles.
- byte_valid_i gaps of any length are tolerated; the partially assembled word is held across them.

## Structure
- Shared package instr_loader_pkg holds:
  - the state enum (LEN_HI, LEN_LO, DATA, FLUSH, DONE, ERR);
  - HDR_BYTES=2 and BYTES_PER_WORD=4.
- Sub-module byte_word_packer:
  - 2-bit byte counter plus a 24-bit shift register;
  - outputs word_valid and word_data on 4th-byte acceptance.
- The top level holds the FSM, the word index/address counter and the output registers.

## Test plan
- Header 0x0002, then bytes 20 08 00 05 00 00 40 20 → im_we_o pulses:
  - addr 0x0 data 0x20080005;
  - addr 0x4 data 0x00004020;
  - done_o and cpu_rst_o high 2 cycles after the last byte; words_o=2.
- Header 0x0000 → done_o=1 one cycle after the second byte; no im_we_o pulse.
- Header 0x0021 with DEPTH_WORDS=32 → err_o=1, byte_ready_o=0, cpu_rst_o stays 0 with further valid bytes offered.
- Two-word image with byte_valid_i toggled randomly (a 3-cycle gap mid-word) → same addresses and data as the back-to-back case; no extra write pulses.
- Assert rst_i low after 5 data bytes of a 3-word image, then send a fresh 1-word image 0x00000001 → one write to addr 0x0 data 0x00000001, words_o=1, done_o=1.
